// File: rtl/pwm_capture_monitor.sv
// Receive-side checker for one complementary gate pair. Measures period,
// high-side on-time and both dead-times in MClk cycles, publishes them with a
// one-cycle Valid, and flags shoot-through, edge-order errors and loss of
// switching.
module pwm_capture_monitor #(
  parameter int BIT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 MClk,
  input  logic                 Rst,
  input  logic                 SHi,
  input  logic                 SLo,
  input  logic [BIT_WIDTH-1:0] TimeoutCount,
  input  logic                 ClearFault,
  output logic [BIT_WIDTH-1:0] Period,
  output logic [BIT_WIDTH-1:0] HighCount,
  output logic [BIT_WIDTH-1:0] DeadFall,
  output logic [BIT_WIDTH-1:0] DeadRise,
  output logic                 Valid,
  output logic                 SeqError,
  output logic                 ShootThrough,
  output logic                 Timeout
);

  typedef enum logic [2:0] {IDLE, HIGH, DFALL, LOW, DRISE} state_t;

  localparam logic [BIT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [BIT_WIDTH-1:0] CNT_ONE = BIT_WIDTH'(1);

  function automatic logic [BIT_WIDTH-1:0] satInc(input logic [BIT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic h, l, hPrev, lPrev;

  generate
    if (SYNC_STAGES > 0) begin : gSync
      logic [SYNC_STAGES-1:0] hSync, lSync;
      // Shift the raw gate pins through the synchroniser chain.
      always_ff @(posedge MClk) begin
        if (Rst) begin
          hSync <= '0;
          lSync <= '0;
        end else begin
          hSync[0] <= SHi;
          lSync[0] <= SLo;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            hSync[i] <= hSync[i-1];
            lSync[i] <= lSync[i-1];
          end
        end
      end
      assign h = hSync[SYNC_STAGES-1];
      assign l = lSync[SYNC_STAGES-1];
    end else begin : gNoSync
      assign h = SHi;
      assign l = SLo;
    end
  endgenerate

  // Previous sample of each gate for edge detection.
  always_ff @(posedge MClk) begin
    if (Rst) begin
      hPrev <= 1'b0;
      lPrev <= 1'b0;
    end else begin
      hPrev <= h;
      lPrev <= l;
    end
  end

  logic hRise, hFall, lRise, lFall, overlap, bothLow;
  assign hRise   = h & ~hPrev;
  assign hFall   = ~h & hPrev;
  assign lRise   = l & ~lPrev;
  assign lFall   = ~l & lPrev;
  assign overlap = h & l;
  assign bothLow = ~h & ~l;

  state_t state, stateNxt;
  logic [BIT_WIDTH-1:0] perCnt, hiCnt, dfCnt, drCnt, idleCnt;
  logic publish, seqErr, enterHigh, toHit;

  // A period that ends exactly on its rise is not a timeout.
  assign toHit = (TimeoutCount != '0) && !hRise &&
                 (((state != IDLE) && (perCnt == TimeoutCount)) ||
                  ((state == IDLE) && (idleCnt == TimeoutCount)));

  // State register.
  always_ff @(posedge MClk) begin
    if (Rst) state <= IDLE;
    else     state <= stateNxt;
  end

  // Edge-order sequencing; any overlap or timeout abandons the period.
  always_comb begin
    stateNxt  = state;
    publish   = 1'b0;
    seqErr    = 1'b0;
    enterHigh = 1'b0;
    if (overlap || toHit) begin
      stateNxt = IDLE;
    end else begin
      case (state)
        IDLE: if (hRise) begin
          stateNxt  = HIGH;
          enterHigh = 1'b1;
        end
        HIGH: if (lRise) begin
          seqErr   = 1'b1;
          stateNxt = IDLE;
        end else if (hFall) begin
          stateNxt = DFALL;
        end
        DFALL: if (hRise) begin
          seqErr    = 1'b1;
          stateNxt  = HIGH;
          enterHigh = 1'b1;
        end else if (lRise) begin
          stateNxt = LOW;
        end
        LOW: if (hRise) begin
          seqErr    = 1'b1;
          stateNxt  = HIGH;
          enterHigh = 1'b1;
        end else if (lFall) begin
          stateNxt = DRISE;
        end
        DRISE: if (lRise) begin
          seqErr   = 1'b1;
          stateNxt = IDLE;
        end else if (hRise) begin
          publish   = 1'b1;
          stateNxt  = HIGH;
          enterHigh = 1'b1;
        end
        default: stateNxt = IDLE;
      endcase
    end
  end

  // Saturating measurement counters; the rise sample itself is the first high cycle.
  always_ff @(posedge MClk) begin
    if (Rst) begin
      perCnt  <= '0;
      hiCnt   <= '0;
      dfCnt   <= '0;
      drCnt   <= '0;
      idleCnt <= '0;
    end else begin
      perCnt  <= hRise ? CNT_ONE : satInc(perCnt);
      idleCnt <= (state == IDLE) ? satInc(idleCnt) : '0;
      if (enterHigh) begin
        hiCnt <= CNT_ONE;
        dfCnt <= '0;
        drCnt <= '0;
      end else begin
        if (state == HIGH && h) hiCnt <= satInc(hiCnt);
        if ((state == HIGH || state == DFALL) && bothLow) dfCnt <= satInc(dfCnt);
        if ((state == LOW || state == DRISE) && bothLow) drCnt <= satInc(drCnt);
      end
    end
  end

  // Published measurements, status pulses and sticky faults (set beats clear).
  always_ff @(posedge MClk) begin
    if (Rst) begin
      Period       <= '0;
      HighCount    <= '0;
      DeadFall     <= '0;
      DeadRise     <= '0;
      Valid        <= 1'b0;
      SeqError     <= 1'b0;
      ShootThrough <= 1'b0;
      Timeout      <= 1'b0;
    end else begin
      Valid        <= publish;
      SeqError     <= seqErr;
      ShootThrough <= overlap | (ShootThrough & ~ClearFault);
      Timeout      <= toHit | (Timeout & ~ClearFault);
      if (publish) begin
        Period    <= perCnt;
        HighCount <= hiCnt;
        DeadFall  <= dfCnt;
        DeadRise  <= drCnt;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture_monitor.sv
// Directed bench: one unsynchronised and one two-stage-synchronised instance
// driven from the same pins.
module tb_pwm_capture_monitor;
  localparam int BW = 16;

  logic MClk = 1'b0;
  logic Rst, SHi, SLo, ClearFault;
  logic [BW-1:0] TimeoutCount;
  logic [BW-1:0] per0, hc0, df0, dr0, per2, hc2, df2, dr2;
  logic val0, se0, st0, to0, val2, se2, st2, to2;

  int cyc = 0;
  int nChk = 0, nPass = 0;
  int v0Cnt = 0, v2Cnt = 0, v0Last = 0, v2Last = 0, v2Prev = 0;
  int s0Cnt = 0, s2Cnt = 0;

  always #5 MClk = ~MClk;

  pwm_capture_monitor #(.BIT_WIDTH(BW), .SYNC_STAGES(0)) dut0 (
    .MClk(MClk), .Rst(Rst), .SHi(SHi), .SLo(SLo), .TimeoutCount(TimeoutCount),
    .ClearFault(ClearFault), .Period(per0), .HighCount(hc0), .DeadFall(df0),
    .DeadRise(dr0), .Valid(val0), .SeqError(se0), .ShootThrough(st0), .Timeout(to0));

  pwm_capture_monitor #(.BIT_WIDTH(BW), .SYNC_STAGES(2)) dut2 (
    .MClk(MClk), .Rst(Rst), .SHi(SHi), .SLo(SLo), .TimeoutCount(TimeoutCount),
    .ClearFault(ClearFault), .Period(per2), .HighCount(hc2), .DeadFall(df2),
    .DeadRise(dr2), .Valid(val2), .SeqError(se2), .ShootThrough(st2), .Timeout(to2));

  always @(posedge MClk) cyc <= cyc + 1;

  // Pulse observers, sampled mid-cycle.
  always @(negedge MClk) begin
    if (val0) begin
      v0Cnt  <= v0Cnt + 1;
      v0Last <= cyc;
    end
    if (val2) begin
      v2Cnt  <= v2Cnt + 1;
      v2Prev <= v2Last;
      v2Last <= cyc;
    end
    if (se0) s0Cnt <= s0Cnt + 1;
    if (se2) s2Cnt <= s2Cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chkMeas(input string tag, input int p, input int hc, input int df, input int dr);
    chk({tag, ".per0"}, 32'(per0), p);
    chk({tag, ".hc0"},  32'(hc0),  hc);
    chk({tag, ".df0"},  32'(df0),  df);
    chk({tag, ".dr0"},  32'(dr0),  dr);
    chk({tag, ".per2"}, 32'(per2), p);
    chk({tag, ".hc2"},  32'(hc2),  hc);
    chk({tag, ".df2"},  32'(df2),  df);
    chk({tag, ".dr2"},  32'(dr2),  dr);
  endtask

  // Hold pins for n samples; returns 1 ns after the last edge.
  task automatic drive(input logic sh, input logic sl, input int n);
    SHi = sh;
    SLo = sl;
    repeat (n) @(posedge MClk);
    #1;
  endtask

  task automatic period(input int hi, input int df, input int lo, input int dr);
    drive(1'b1, 1'b0, hi);
    drive(1'b0, 1'b0, df);
    drive(1'b0, 1'b1, lo);
    drive(1'b0, 1'b0, dr);
  endtask

  initial begin
    int tR, vb0, vb2, sb0, sb2;
    Rst = 1'b1; SHi = 1'b0; SLo = 1'b0; ClearFault = 1'b0; TimeoutCount = '0;
    repeat (3) @(posedge MClk);
    #1;
    chkMeas("reset", 0, 0, 0, 0);
    chk("reset.flags0", 32'({val0, se0, st0, to0}), 0);
    chk("reset.flags2", 32'({val2, se2, st2, to2}), 0);
    Rst = 1'b0;
    drive(1'b0, 1'b0, 4);

    // Clean repeating pattern: first rise only arms, then one Valid per period.
    vb0 = v0Cnt; vb2 = v2Cnt;
    repeat (4) period(10, 2, 6, 2);
    tR = cyc;
    drive(1'b1, 1'b0, 10);
    chk("clean.count0", v0Cnt - vb0, 4);
    chk("clean.count2", v2Cnt - vb2, 4);
    chk("clean.lat0", v0Last, tR + 1);
    chk("clean.lat2", v2Last, tR + 3);
    chk("clean.spacing2", v2Last - v2Prev, 20);
    chkMeas("clean", 20, 10, 2, 2);
    drive(1'b0, 1'b0, 2); drive(1'b0, 1'b1, 6); drive(1'b0, 1'b0, 2);

    // One-cycle overlap mid-HIGH.
    drive(1'b1, 1'b0, 4);
    vb0 = v0Cnt; vb2 = v2Cnt;
    drive(1'b1, 1'b1, 1);
    drive(1'b1, 1'b0, 5);
    chk("shoot.flag0", 32'(st0), 1);
    chk("shoot.flag2", 32'(st2), 1);
    drive(1'b0, 1'b0, 2); drive(1'b0, 1'b1, 6); drive(1'b0, 1'b0, 2);
    period(10, 2, 6, 2);
    chk("shoot.novalid0", v0Cnt - vb0, 0);
    chk("shoot.novalid2", v2Cnt - vb2, 0);
    drive(1'b1, 1'b0, 10);
    chk("shoot.resume0", v0Cnt - vb0, 1);
    chk("shoot.resume2", v2Cnt - vb2, 1);
    chkMeas("shoot", 20, 10, 2, 2);
    ClearFault = 1'b1; drive(1'b1, 1'b0, 1); ClearFault = 1'b0;
    chk("clear.flag0", 32'(st0), 0);
    chk("clear.flag2", 32'(st2), 0);
    ClearFault = 1'b1; drive(1'b1, 1'b1, 1); ClearFault = 1'b0;
    chk("clearvsset.flag0", 32'(st0), 1);
    drive(1'b1, 1'b0, 3);
    chk("clearvsset.flag2", 32'(st2), 1);
    ClearFault = 1'b1; drive(1'b1, 1'b0, 1); ClearFault = 1'b0;
    chk("clear2.flag0", 32'(st0), 0);
    chk("clear2.flag2", 32'(st2), 0);
    drive(1'b0, 1'b0, 2); drive(1'b0, 1'b1, 6); drive(1'b0, 1'b0, 2);

    // Missing low pulse: second h rise lands in DFALL.
    vb0 = v0Cnt; vb2 = v2Cnt; sb0 = s0Cnt; sb2 = s2Cnt;
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 10);
    drive(1'b1, 1'b0, 7);
    chk("seq.pulse0", s0Cnt - sb0, 1);
    chk("seq.pulse2", s2Cnt - sb2, 1);
    chk("seq.novalid0", v0Cnt - vb0, 0);
    chk("seq.novalid2", v2Cnt - vb2, 0);
    drive(1'b0, 1'b0, 3); drive(1'b0, 1'b1, 5); drive(1'b0, 1'b0, 4);
    drive(1'b1, 1'b0, 10);
    chk("seq.resume0", v0Cnt - vb0, 1);
    chk("seq.resume2", v2Cnt - vb2, 1);
    chkMeas("seq", 19, 7, 3, 4);

    // Timeout 50 cycles after a rise with both gates then held low.
    TimeoutCount = 16'd50;
    drive(1'b0, 1'b0, 2); drive(1'b0, 1'b1, 6); drive(1'b0, 1'b0, 2);
    tR = cyc;
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b0, 49);
    chk("to.early0", 32'(to0), 0);
    chk("to.early2", 32'(to2), 0);
    chk("to.cyc", cyc, tR + 50);
    drive(1'b0, 1'b0, 1);
    chk("to.hit0", 32'(to0), 1);
    chk("to.notyet2", 32'(to2), 0);
    drive(1'b0, 1'b0, 1);
    chk("to.notyet2b", 32'(to2), 0);
    drive(1'b0, 1'b0, 1);
    chk("to.hit2", 32'(to2), 1);
    ClearFault = 1'b1; drive(1'b0, 1'b0, 1); ClearFault = 1'b0;
    chk("to.clear0", 32'(to0), 0);
    chk("to.clear2", 32'(to2), 0);
    vb0 = v0Cnt; vb2 = v2Cnt;
    period(10, 2, 6, 2);
    chk("to.restart.novalid0", v0Cnt - vb0, 0);
    chk("to.restart.novalid2", v2Cnt - vb2, 0);
    drive(1'b1, 1'b0, 10);
    chk("to.restart.valid0", v0Cnt - vb0, 1);
    chk("to.restart.valid2", v2Cnt - vb2, 1);
    chkMeas("to.restart", 20, 10, 2, 2);

    // Long HIGH saturates the period and on-time counters.
    TimeoutCount = '0;
    drive(1'b0, 1'b0, 2); drive(1'b0, 1'b1, 6); drive(1'b0, 1'b0, 2);
    drive(1'b1, 1'b0, 66000);
    drive(1'b0, 1'b0, 2); drive(1'b0, 1'b1, 6); drive(1'b0, 1'b0, 2);
    vb0 = v0Cnt; vb2 = v2Cnt;
    drive(1'b1, 1'b0, 5);
    chk("sat.valid0", v0Cnt - vb0, 1);
    chk("sat.valid2", v2Cnt - vb2, 1);
    chkMeas("sat", 65535, 65535, 2, 2);

    // Reset mid-period clears everything, sticky flags included.
    drive(1'b1, 1'b1, 1);
    drive(1'b1, 1'b0, 3);
    chk("rst.pre.flag0", 32'(st0), 1);
    chk("rst.pre.flag2", 32'(st2), 1);
    Rst = 1'b1;
    drive(1'b0, 1'b0, 1);
    chkMeas("rst.mid", 0, 0, 0, 0);
    chk("rst.mid.flags0", 32'({val0, se0, st0, to0}), 0);
    chk("rst.mid.flags2", 32'({val2, se2, st2, to2}), 0);
    Rst = 1'b0;
    vb0 = v0Cnt; vb2 = v2Cnt;
    drive(1'b0, 1'b0, 2); drive(1'b0, 1'b1, 6); drive(1'b0, 1'b0, 2);
    drive(1'b1, 1'b0, 10);
    chk("rst.first.novalid0", v0Cnt - vb0, 0);
    chk("rst.first.novalid2", v2Cnt - vb2, 0);
    chk("rst.first.per0", 32'(per0), 0);
    drive(1'b0, 1'b0, 2); drive(1'b0, 1'b1, 6); drive(1'b0, 1'b0, 2);
    drive(1'b1, 1'b0, 10);
    chk("rst.second.valid0", v0Cnt - vb0, 1);
    chk("rst.second.valid2", v2Cnt - vb2, 1);
    chkMeas("rst.second", 20, 10, 2, 2);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
